conv_top: RTL and testbench
===========================

CONV_TOP -- requirements
Module: conv_top

Interface
REQ-001 Parameter IMG, default 14, valid convolution-output width/height before pooling; even, ≥2.
REQ-002 Parameter PAD, default 1, zero-pad border width already present in the streamed image; input edge SIZE = IMG+2*PAD; only PAD=1 is supported.
REQ-003 Parameter FRAC, default 8, fixed-point fraction bits removed from each convolution sum.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 w_load  input  1  weight-load request.
REQ-007 i_load  input  1  image-load request.
REQ-008 img_in  input  16 signed  shared serial data bus carrying weights and then pixels.
REQ-009 pooling_out  output  16 signed  2x2 max-pooled convolution result.
REQ-010 done_pooling  output  1  one-cycle strobe; pooling_out is valid while high.

Function
REQ-011 FSM states: IDLE, WLOAD, ILOAD, CONV, and back to IDLE; only IDLE accepts load requests.
REQ-012 In IDLE, a cycle sampling w_load=1 arms the weight load; WLOAD starts at the first later edge sampling w_load=0.
REQ-013 In WLOAD, img_in is captured on 9 consecutive edges as weights w[0..8], 3x3 row-major, the first capture on the WLOAD-entry edge; the FSM then returns to IDLE.
REQ-014 In IDLE, i_load is armed the same way; ILOAD captures SIZE*SIZE pixels (256 at defaults) on consecutive edges, row-major, into an internal SIZExSIZE signed 16-bit buffer; the FSM then enters CONV.
REQ-015 If w_load and i_load are both high in IDLE, w_load wins and i_load is ignored; both are ignored outside IDLE.
REQ-016 Weights persist across image loads until reloaded or reset.
REQ-017 Convolution: stride 1, no extra padding; conv(r,c) = sum over i,j in 0..2 of pix[r+i][c+j]*w[3i+j], for r,c in 0..IMG-1.
REQ-018 Arithmetic: products are 32-bit signed; the accumulator is ≥36-bit signed; the result is the sum arithmetically shifted right by FRAC, then saturated to [-32768, 32767].
REQ-019 CONV evaluates one conv(r,c) per cycle, in pooling-window order: windows row-major; within a window (2R,2C), (2R,2C+1), (2R+1,2C), (2R+1,2C+1).
REQ-020 After the 4th element of each window, pooling_out = signed max of the 4 results and done_pooling=1 for exactly one cycle; the strobe is registered and appears one cycle after the 4th evaluation.
REQ-021 The strobe period is 4 cycles; (IMG/2)^2 strobes (49 at defaults) per image; the first strobe comes 5 cycles after CONV entry; IDLE is re-entered after the last strobe.
REQ-022 pooling_out holds its last value between strobes.
REQ-023 Signed max with ties outputs the equal value; all-negative windows output the least-negative value.

Reset
REQ-024 On rst_n=0, immediately: FSM=IDLE, load arming cleared, counters=0, pooling_out=0, done_pooling=0, weights=0.
REQ-025 The image buffer need not be reset.
REQ-026 Reset asserted mid-load or mid-CONV aborts the operation with no further strobes; weights are zeroed, so operation restarts from a weight load.

Configuration
REQ-027 Macro CONV_TOP_RELU_EN: when defined, each saturated convolution result is clamped to ≥0 before pooling, so pooling_out is never negative.
REQ-028 Without CONV_TOP_RELU_EN, signed results pass to pooling unmodified.

Verification
REQ-029 Reset: rst_n low mid-CONV -> done_pooling=0 and pooling_out=0 within the same cycle; no strobes afterwards.
REQ-030 Identity kernel: weights {0,0,0,0,256,0,0,0,0}, FRAC=8, image pix=index 0..255 -> 49 strobes 4 cycles apart; first = pix[2][2]=34; last = pix[14][14]=238.
REQ-031 All-ones kernel: w=256 each, image all 1 -> every output 9; with border pixels 0 and interior 1 -> first output 9 (window (0,0): conv(0,0)=4, conv(0,1)=6, conv(1,0)=6, conv(1,1)=9).
REQ-032 Saturation: all w=32767, all pix=32767 -> every output 32767; all w=-32768, all pix=32767 -> -32768 without CONV_TOP_RELU_EN, 0 with it.
REQ-033 Protocol: w_load and i_load high together in IDLE -> only weights load; i_load and w_load pulses during CONV are ignored; the strobe count stays 49.
REQ-034 Weight retention: two image loads after one weight load -> both produce correct, independent results.

Source files
------------

// File: rtl/conv_top.sv
// conv_top: serial-loaded 3x3 convolution followed by 2x2 max pooling.
// Optional ReLU before pooling is enabled by defining CONV_TOP_RELU_EN.
module conv_top #(
    parameter int IMG  = 14,
    parameter int PAD  = 1,
    parameter int FRAC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w_load,
    input  logic               i_load,
    input  logic signed [15:0] img_in,
    output logic signed [15:0] pooling_out,
    output logic               done_pooling
);
    localparam int SIZE = IMG + 2 * PAD;
    localparam int NPIX = SIZE * SIZE;
    localparam int HALF = IMG / 2;
    localparam int AW   = $clog2(NPIX);
    localparam int HW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {IDLE, WLOAD, ILOAD, CONV} state_t;

    state_t             r_state;
    logic               r_w_arm, r_i_arm;
    logic [AW-1:0]      r_cnt;
    logic [1:0]         r_k;
    logic [HW-1:0]      r_wr, r_wc;
    logic signed [15:0] r_w [9];
    logic signed [15:0] r_pix [NPIX];
    logic signed [15:0] r_res, r_max, r_pool;
    logic [1:0]         r_res_k;
    logic               r_res_v, r_done;

    logic               w_go_w, w_go_i, w_pix_we, w_eval;
    logic [AW-1:0]      w_pix_addr, w_r, w_c;
    logic signed [31:0] w_prod [9];
    logic signed [35:0] w_acc, w_sh;
    logic signed [15:0] w_sat, w_val, w_mx;

    // The first word of a load is captured on the same edge that leaves IDLE
    assign w_go_w     = r_state == IDLE && r_w_arm && !w_load;
    assign w_go_i     = r_state == IDLE && r_i_arm && !i_load;
    assign w_pix_we   = w_go_i || r_state == ILOAD;
    assign w_pix_addr = r_state == ILOAD ? r_cnt : '0;
    // Window-row counter running one past the end marks the drain cycle
    assign w_eval     = r_state == CONV && r_wr < HW'(HALF);
    assign w_r        = AW'({r_wr, r_k[1]});
    assign w_c        = AW'({r_wc, r_k[0]});

    for (genvar g = 0; g < 9; g++) begin : g_tap
        assign w_prod[g] = r_pix[(w_r + AW'(g / 3)) * AW'(SIZE) + w_c + AW'(g % 3)] * r_w[g];
    end

    // Sum the nine taps in a wide accumulator so no intermediate overflows
    always_comb begin
        w_acc = '0;
        for (int t = 0; t < 9; t++) w_acc = w_acc + 36'(w_prod[t]);
    end

    assign w_sh  = w_acc >>> FRAC;
    assign w_sat = w_sh > 36'sd32767 ? 16'sd32767 : w_sh < -36'sd32768 ? -16'sd32768 : w_sh[15:0];
`ifdef CONV_TOP_RELU_EN
    assign w_val = w_sat[15] ? '0 : w_sat;
`else
    assign w_val = w_sat;
`endif
    assign w_mx  = (r_res_k == 2'd0 || r_res > r_max) ? r_res : r_max;

    // Control FSM: load arming, weight capture, load/scan counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_w_arm <= 1'b0;
            r_i_arm <= 1'b0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_wr    <= '0;
            r_wc    <= '0;
            for (int t = 0; t < 9; t++) r_w[t] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go_w) begin
                        r_w_arm <= 1'b0;
                        r_w[0]  <= img_in;
                        r_cnt   <= AW'(1);
                        r_state <= WLOAD;
                    end else if (w_load) begin
                        r_w_arm <= 1'b1;
                        r_i_arm <= 1'b0;
                    end else if (w_go_i) begin
                        r_i_arm <= 1'b0;
                        r_cnt   <= AW'(1);
                        r_state <= ILOAD;
                    end else if (i_load) begin
                        r_i_arm <= 1'b1;
                    end
                end
                WLOAD: begin
                    r_w[r_cnt[3:0]] <= img_in;
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(8)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                ILOAD: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(NPIX - 1)) begin
                        r_cnt   <= '0;
                        r_k     <= '0;
                        r_wr    <= '0;
                        r_wc    <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    if (w_eval) begin
                        r_k <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            if (r_wc == HW'(HALF - 1)) begin
                                r_wc <= '0;
                                r_wr <= r_wr + HW'(1);
                            end else begin
                                r_wc <= r_wc + HW'(1);
                            end
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Image buffer is write-only from the stream and needs no reset
    always_ff @(posedge clk) begin
        if (w_pix_we) r_pix[w_pix_addr] <= img_in;
    end

    // Register each conv result, fold into the window max, strobe on the 4th
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_v <= 1'b0;
            r_res   <= '0;
            r_res_k <= '0;
            r_max   <= '0;
            r_pool  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_res_v <= w_eval;
            r_res   <= w_val;
            r_res_k <= r_k;
            r_done  <= r_res_v && r_res_k == 2'd3;
            if (r_res_v) r_max <= w_mx;
            if (r_res_v && r_res_k == 2'd3) r_pool <= w_mx;
        end
    end

    assign pooling_out  = r_pool;
    assign done_pooling = r_done;
endmodule

// File: tb/tb_conv_top.sv
// tb_conv_top: directed-vector bench for conv_top at default parameters.
module tb_conv_top;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               w_load = 1'b0;
    logic               i_load = 1'b0;
    logic signed [15:0] img_in = '0;
    logic signed [15:0] pooling_out;
    logic               done_pooling;

`ifdef CONV_TOP_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic signed [15:0] tw [9];
    logic signed [15:0] tp [256];
    longint gv[$];
    int gc[$];

    conv_top dut (
        .clk(clk),
        .rst_n(rst_n),
        .w_load(w_load),
        .i_load(i_load),
        .img_in(img_in),
        .pooling_out(pooling_out),
        .done_pooling(done_pooling)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int m);
        for (int t = 0; t < 9; t++)
            tw[t] = 16'(m == 0 ? (t == 4 ? 256 : 0) : m == 1 ? 256 : m == 2 ? 32767 :
                        m == 3 ? -32768 : (t == 4 ? -256 : 0));
    endtask

    task automatic set_p(input int m);
        for (int t = 0; t < 256; t++) begin
            bit border;
            border = (t / 16 == 0) || (t / 16 == 15) || (t % 16 == 0) || (t % 16 == 15);
            tp[t] = 16'(m == 0 ? t : m == 1 ? 1 : m == 2 ? (border ? 0 : 1) : m == 3 ? 32767 : 255 - t);
        end
    endtask

    task automatic load_w(input bit with_i);
        w_load = 1'b1;
        i_load = with_i;
        tick;
        w_load = 1'b0;
        i_load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            img_in = tw[k];
            tick;
        end
    endtask

    task automatic load_img;
        i_load = 1'b1;
        tick;
        i_load = 1'b0;
        for (int k = 0; k < 256; k++) begin
            img_in = tp[k];
            tick;
        end
    endtask

    function automatic longint expv(input int m, input int r, input int c);
        case (m)
            0: return longint'((2 * r + 2) * 16 + 2 * c + 2);
            1: return 9;
            2: return 32767;
            3: return RELU ? 0 : -32768;
            4: return longint'(255 - ((2 * r + 1) * 16 + 2 * c + 1));
            5: return RELU ? 0 : -longint'((2 * r + 1) * 16 + 2 * c + 1);
            default: return 0;
        endcase
    endfunction

    // Called right after the CONV-entry edge; collects strobes for a bounded window
    task automatic run_conv(input string tag, input int m, input bit inj);
        int bad_v = 0;
        int bad_p = 0;
        int bad_h = 0;
        longint last = 0;
        gv.delete();
        gc.delete();
        for (int cyc = 1; cyc <= 230; cyc++) begin
            if (inj) begin
                i_load = (cyc >= 10 && cyc < 12) || cyc == 60;
                w_load = cyc == 30 || cyc == 60;
            end
            tick;
            if (done_pooling) begin
                gv.push_back(pooling_out);
                gc.push_back(cyc);
                last = pooling_out;
            end else if (gv.size() > 0 && longint'(pooling_out) != last) begin
                bad_h++;
            end
        end
        i_load = 1'b0;
        w_load = 1'b0;
        check_val({tag, "_count"}, gv.size(), 49);
        for (int i = 0; i < gv.size(); i++) begin
            if (gv[i] != expv(m, i / 7, i % 7)) bad_v++;
            if (i > 0 && gc[i] - gc[i-1] != 4) bad_p++;
        end
        check_val({tag, "_values_bad"}, bad_v, 0);
        check_val({tag, "_period_bad"}, bad_p, 0);
        check_val({tag, "_hold_bad"}, bad_h, 0);
        if (gv.size() > 0) begin
            check_val({tag, "_first_cyc"}, gc[0], 5);
            check_val({tag, "_first"}, gv[0], expv(m, 0, 0));
            check_val({tag, "_last"}, gv[gv.size()-1], expv(m, 6, 6));
        end
    endtask

    initial begin
        int n;
        int k;
        tick;
        tick;
        check_val("reset_done", done_pooling, 0);
        check_val("reset_pool", pooling_out, 0);
        rst_n = 1'b1;
        tick;

        set_w(0);
        load_w(1'b0);
        set_p(0);
        load_img;
        run_conv("ident", 0, 1'b0);
        set_p(4);
        load_img;
        run_conv("retain_rev", 4, 1'b0);

        set_w(1);
        load_w(1'b0);
        set_p(1);
        load_img;
        run_conv("ones", 1, 1'b0);
        set_p(2);
        load_img;
        run_conv("border", 1, 1'b0);

        set_w(2);
        load_w(1'b0);
        set_p(3);
        load_img;
        run_conv("sat_pos", 2, 1'b0);
        set_w(3);
        load_w(1'b0);
        load_img;
        run_conv("sat_neg", 3, 1'b0);

        set_w(4);
        load_w(1'b0);
        set_p(0);
        load_img;
        run_conv("neg_ident", 5, 1'b0);

        set_w(0);
        load_w(1'b1);
        n = 0;
        repeat (300) begin
            tick;
            if (done_pooling) n++;
        end
        check_val("proto_no_iload", n, 0);
        load_img;
        run_conv("proto_inj", 0, 1'b1);

        load_img;
        k = 0;
        while (!done_pooling && k < 50) begin
            tick;
            k++;
        end
        check_val("rst_strobe_seen", done_pooling, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_done", done_pooling, 0);
        check_val("rst_pool", pooling_out, 0);
        tick;
        tick;
        rst_n = 1'b1;
        n = 0;
        repeat (250) begin
            tick;
            if (done_pooling) n++;
        end
        check_val("rst_no_strobe", n, 0);
        load_img;
        run_conv("rst_zero_w", 6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
